// File: rtl/iob_fifo_sync_asym.sv
// Synchronous FIFO with independent write and read word widths.
// Storage is split into one narrow-unit bank per lane of the wider port so a
// wide access touches every bank on the same row, while a narrow access picks
// a single bank. Each bank is a simple dual-port array with a registered read.
module iob_fifo_sync_asym #(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_en,
  input  logic [W_DATA_W-1:0] w_data,
  output logic                w_full,
  input  logic                r_en,
  output logic [R_DATA_W-1:0] r_data,
  output logic                r_valid,
  output logic                r_empty,
  output logic [ADDR_W:0]     level
);

  // Geometry: narrow unit width, per-port unit counts, bank and row layout.
  localparam int MIN_W   = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W;
  localparam int MAX_W   = (W_DATA_W < R_DATA_W) ? R_DATA_W : W_DATA_W;
  localparam int W_UNITS = W_DATA_W / MIN_W;
  localparam int R_UNITS = R_DATA_W / MIN_W;
  localparam int BANKS   = MAX_W / MIN_W;
  localparam int BANK_W  = $clog2(BANKS);
  localparam int SEL_W   = (BANK_W > 0) ? BANK_W : 1;
  localparam int ROW_W   = ADDR_W - BANK_W;
  localparam int ROWS    = 1 << ROW_W;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int LVL_W   = ADDR_W + 1;

  // Reject unsupported width ratios or a memory too small to hold one wide word.
  generate
    if ((MAX_W % MIN_W != 0) ||
        !(BANKS == 1 || BANKS == 2 || BANKS == 4 || BANKS == 8)) begin : g_bad_ratio
      $error("iob_fifo_sync_asym: width ratio must be 1, 2, 4 or 8");
    end
    if (ADDR_W <= BANK_W) begin : g_bad_depth
      $error("iob_fifo_sync_asym: ADDR_W too small for the width ratio");
    end
  endgenerate

  logic [ADDR_W-1:0] w_ptr_reg, w_ptr_next;
  logic [ADDR_W-1:0] r_ptr_reg, r_ptr_next;
  logic [LVL_W-1:0]  level_reg, level_next;
  logic [SEL_W-1:0]  r_sel_reg;
  logic              r_valid_reg;

  logic              w_accept;
  logic              r_accept;
  logic [SEL_W-1:0]  w_sel;
  logic [SEL_W-1:0]  r_sel;
  logic [ROW_W-1:0]  w_row;
  logic [ROW_W-1:0]  r_row;
  logic [MIN_W-1:0]  bank_q [BANKS];

  // Status flags come straight from the occupancy count.
  assign w_full  = (level_reg > LVL_W'(DEPTH - W_UNITS));
  assign r_empty = (level_reg < LVL_W'(R_UNITS));

  assign w_accept = w_en & ~w_full;
  assign r_accept = r_en & ~r_empty;

  // Low pointer bits choose the bank (lane), the remaining bits the row.
  assign w_row = w_ptr_reg[ADDR_W-1:BANK_W];
  assign r_row = r_ptr_reg[ADDR_W-1:BANK_W];

  generate
    if (BANK_W > 0) begin : g_sel
      assign w_sel = w_ptr_reg[SEL_W-1:0];
      assign r_sel = r_ptr_reg[SEL_W-1:0];
    end else begin : g_nosel
      assign w_sel = '0;
      assign r_sel = '0;
    end
  endgenerate

  // Next-state for pointers and occupancy; both ports may act in one cycle.
  always_comb begin
    w_ptr_next = w_ptr_reg;
    r_ptr_next = r_ptr_reg;
    level_next = level_reg;
    if (w_accept) begin
      w_ptr_next = w_ptr_reg + ADDR_W'(W_UNITS);
      level_next = level_next + LVL_W'(W_UNITS);
    end
    if (r_accept) begin
      r_ptr_next = r_ptr_reg + ADDR_W'(R_UNITS);
      level_next = level_next - LVL_W'(R_UNITS);
    end
  end

  // Pointer, occupancy and read-status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr_reg   <= '0;
      r_ptr_reg   <= '0;
      level_reg   <= '0;
      r_sel_reg   <= '0;
      r_valid_reg <= 1'b0;
    end else begin
      w_ptr_reg   <= w_ptr_next;
      r_ptr_reg   <= r_ptr_next;
      level_reg   <= level_next;
      r_valid_reg <= r_accept;
      if (r_accept) begin
        r_sel_reg <= r_sel;
      end
    end
  end

  // One narrow-unit bank per lane of the wider port.
  genvar gi;
  generate
    for (gi = 0; gi < BANKS; gi++) begin : g_bank
      // A write covers lanes [W_BASE, W_BASE+W_UNITS); this bank is lane W_LANE of it.
      localparam int W_BASE = gi - (gi % W_UNITS);
      localparam int W_LANE = gi % W_UNITS;

      logic [MIN_W-1:0] mem [ROWS];
      logic [MIN_W-1:0] bank_q_reg;
      logic             bank_we;

      assign bank_we = w_accept && (w_sel == SEL_W'(W_BASE));

      // Write port: store this lane's unit of the incoming word.
      always_ff @(posedge clk) begin
        if (bank_we) begin
          mem[w_row] <= w_data[W_LANE*MIN_W +: MIN_W];
        end
      end

      // Registered read port; only loads on an accepted read so r_data holds.
      always_ff @(posedge clk) begin
        if (rst) begin
          bank_q_reg <= '0;
        end else if (r_accept) begin
          bank_q_reg <= mem[r_row];
        end
      end

      assign bank_q[gi] = bank_q_reg;
    end

    // Reassemble the read word: output lane k comes from bank (base + k).
    for (gi = 0; gi < R_UNITS; gi++) begin : g_rlane
      assign r_data[gi*MIN_W +: MIN_W] = bank_q[r_sel_reg + SEL_W'(gi)];
    end
  endgenerate

  assign r_valid = r_valid_reg;
  assign level   = level_reg;

endmodule

// File: tb/tb_iob_fifo_sync_asym.sv
// Bench for iob_fifo_sync_asym: one 32->8 instance (a) and one 8->32 instance (b).
// Directed table vectors, hand sequences for reset/wrap, then random traffic
// checked against a byte-queue model of FIFO contents.
module tb_iob_fifo_sync_asym;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_w_en, a_r_en, a_w_full, a_r_valid, a_r_empty;
  logic [31:0] a_w_data;
  logic [7:0]  a_r_data;
  logic [4:0]  a_level;

  logic        b_w_en, b_r_en, b_w_full, b_r_valid, b_r_empty;
  logic [7:0]  b_w_data;
  logic [31:0] b_r_data;
  logic [4:0]  b_level;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iob_fifo_sync_asym #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4)) dut_a (
    .clk(clk), .rst(rst),
    .w_en(a_w_en), .w_data(a_w_data), .w_full(a_w_full),
    .r_en(a_r_en), .r_data(a_r_data), .r_valid(a_r_valid), .r_empty(a_r_empty),
    .level(a_level)
  );

  iob_fifo_sync_asym #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .w_en(b_w_en), .w_data(b_w_data), .w_full(b_w_full),
    .r_en(b_r_en), .r_data(b_r_data), .r_valid(b_r_valid), .r_empty(b_r_empty),
    .level(b_level)
  );

  typedef struct {
    bit          sel;     // 0 = dut_a, 1 = dut_b
    bit          w_en;
    logic [31:0] w_data;
    bit          r_en;
    int          lvl;
    bit          valid;
    logic [31:0] rdata;
    bit          full;
    bit          empty;
  } vec_t;

  vec_t vecs[$];

  // Reference model: FIFO contents as bytes, oldest first.
  logic [7:0]  qa[$];
  logic [7:0]  qb[$];
  logic [7:0]  a_rd_exp;
  logic [31:0] b_rd_exp;
  bit          a_v_exp, b_v_exp;

  function automatic void add(bit sel, bit we, logic [31:0] wd, bit re, int lvl,
                              bit v, logic [31:0] rd, bit full, bit empty);
    vec_t t;
    t.sel = sel; t.w_en = we; t.w_data = wd; t.r_en = re; t.lvl = lvl;
    t.valid = v; t.rdata = rd; t.full = full; t.empty = empty;
    vecs.push_back(t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    a_w_en = 0; a_r_en = 0; a_w_data = '0;
    b_w_en = 0; b_r_en = 0; b_w_data = '0;
  endtask

  task automatic model_clear();
    qa.delete(); qb.delete();
    a_rd_exp = '0; b_rd_exp = '0;
    a_v_exp = 0; b_v_exp = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    tick();
    rst = 0;
    model_clear();
  endtask

  // One clock of traffic on both instances, then compare against the model.
  task automatic step_both(input bit awe, input logic [31:0] awd, input bit are,
                           input bit bwe, input logic [7:0] bwd, input bit bre,
                           input string tag);
    bit aw, ar, bw, br;
    aw = awe && !(qa.size() > 16 - 4);
    ar = are && (qa.size() >= 1);
    bw = bwe && !(qb.size() > 16 - 1);
    br = bre && (qb.size() >= 4);
    a_w_en = awe; a_w_data = awd; a_r_en = are;
    b_w_en = bwe; b_w_data = bwd; b_r_en = bre;
    tick();
    if (ar) a_rd_exp = qa.pop_front();
    a_v_exp = ar;
    if (aw) for (int k = 0; k < 4; k++) qa.push_back(awd[k*8 +: 8]);
    if (br) for (int k = 0; k < 4; k++) b_rd_exp[k*8 +: 8] = qb.pop_front();
    b_v_exp = br;
    if (bw) qb.push_back(bwd);
    chk({tag, "_a_level"}, 32'(a_level), 32'(qa.size()));
    chk({tag, "_a_valid"}, 32'(a_r_valid), 32'(a_v_exp));
    chk({tag, "_a_rdata"}, 32'(a_r_data), 32'(a_rd_exp));
    chk({tag, "_a_full"}, 32'(a_w_full), 32'(qa.size() > 12));
    chk({tag, "_a_empty"}, 32'(a_r_empty), 32'(qa.size() < 1));
    chk({tag, "_b_level"}, 32'(b_level), 32'(qb.size()));
    chk({tag, "_b_valid"}, 32'(b_r_valid), 32'(b_v_exp));
    chk({tag, "_b_rdata"}, b_r_data, b_rd_exp);
    chk({tag, "_b_full"}, 32'(b_w_full), 32'(qb.size() > 15));
    chk({tag, "_b_empty"}, 32'(b_r_empty), 32'(qb.size() < 4));
    $display("%s a:we=%0d re=%0d acc=%0d/%0d lvl=%0d rd=%h  b:we=%0d re=%0d acc=%0d/%0d lvl=%0d rd=%h",
             tag, awe, are, aw, ar, a_level, a_r_data, bwe, bre, bw, br, b_level, b_r_data);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        v;
    int          wr_words, rd_units, cyc;
    bit          we, re, wacc, racc;
    logic [31:0] wd;
    logic [7:0]  exp_byte;

    // ---- reset state ----
    do_reset();
    chk("rst_a_level", 32'(a_level), 0);
    chk("rst_a_empty", 32'(a_r_empty), 1);
    chk("rst_a_full", 32'(a_w_full), 0);
    chk("rst_a_rdata", 32'(a_r_data), 0);
    chk("rst_a_valid", 32'(a_r_valid), 0);
    chk("rst_b_level", 32'(b_level), 0);
    chk("rst_b_empty", 32'(b_r_empty), 1);
    chk("rst_b_rdata", b_r_data, 0);

    // ---- directed table ----
    // a: one wide write, four narrow reads
    add(0, 1, 32'h23222120, 0, 4, 0, 32'h00, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 0, 0, 1, 3 - k, 1, 32'h20 + k, 0, k == 3);
    add(0, 0, 0, 0, 0, 0, 32'h23, 0, 1);
    // a: fill to 16, overflow write ignored, drain 16 in order
    for (int k = 0; k < 4; k++)
      add(0, 1, 32'h23222120 + k * 32'h04040404, 0, 4 * (k + 1), 0, 32'h23, k == 3, 0);
    add(0, 1, 32'hDEADBEEF, 0, 16, 0, 32'h23, 1, 0);
    for (int k = 0; k < 16; k++) add(0, 0, 0, 1, 15 - k, 1, 32'h20 + k, (15 - k) > 12, k == 15);
    // a: simultaneous write and read at level 8
    add(0, 1, 32'h53525150, 0, 4, 0, 32'h2F, 0, 0);
    add(0, 1, 32'h57565554, 0, 8, 0, 32'h2F, 0, 0);
    add(0, 1, 32'h5B5A5958, 1, 11, 1, 32'h50, 0, 0);
    for (int k = 0; k < 11; k++) add(0, 0, 0, 1, 10 - k, 1, 32'h51 + k, 0, k == 10);
    // b: narrow writes, read ignored until a full wide word exists
    for (int k = 0; k < 3; k++) add(1, 1, 32'h20 + k, 0, k + 1, 0, 0, 0, 1);
    add(1, 0, 0, 1, 3, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) add(1, 1, 32'h23 + k, 0, 4 + k, 0, 0, 0, 0);
    add(1, 0, 0, 1, 4, 1, 32'h23222120, 0, 0);
    add(1, 0, 0, 1, 0, 1, 32'h27262524, 0, 1);
    add(1, 0, 0, 0, 0, 0, 32'h27262524, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      idle_inputs();
      if (!v.sel) begin
        a_w_en = v.w_en; a_w_data = v.w_data; a_r_en = v.r_en;
      end else begin
        b_w_en = v.w_en; b_w_data = v.w_data[7:0]; b_r_en = v.r_en;
      end
      tick();
      if (!v.sel) begin
        chk("tbl_a_level", 32'(a_level), 32'(v.lvl));
        chk("tbl_a_valid", 32'(a_r_valid), 32'(v.valid));
        chk("tbl_a_rdata", 32'(a_r_data), v.rdata);
        chk("tbl_a_full", 32'(a_w_full), 32'(v.full));
        chk("tbl_a_empty", 32'(a_r_empty), 32'(v.empty));
      end else begin
        chk("tbl_b_level", 32'(b_level), 32'(v.lvl));
        chk("tbl_b_valid", 32'(b_r_valid), 32'(v.valid));
        chk("tbl_b_rdata", b_r_data, v.rdata);
        chk("tbl_b_full", 32'(b_w_full), 32'(v.full));
        chk("tbl_b_empty", 32'(b_r_empty), 32'(v.empty));
      end
      $display("vec %0d dut=%0d we=%0d wd=%h re=%0d", i, v.sel, v.w_en, v.w_data, v.r_en);
    end
    idle_inputs();

    // ---- reset in the middle of operation ----
    do_reset();
    for (int k = 0; k < 4; k++)
      step_both(1, 32'h13121110 + k * 32'h04040404, 0, 0, 0, 0, "mrst_fill");
    for (int k = 0; k < 4; k++) step_both(0, 0, 1, 0, 0, 0, "mrst_read");
    chk("mrst_pre_level", 32'(a_level), 12);
    rst = 1; a_w_en = 1; a_w_data = 32'hFFFFFFFF; a_r_en = 1;
    tick();
    rst = 0; idle_inputs(); model_clear();
    chk("mrst_level", 32'(a_level), 0);
    chk("mrst_empty", 32'(a_r_empty), 1);
    chk("mrst_full", 32'(a_w_full), 0);
    chk("mrst_rdata", 32'(a_r_data), 0);
    chk("mrst_valid", 32'(a_r_valid), 0);
    $display("mid-op reset applied");
    step_both(1, 32'h33323130, 0, 0, 0, 0, "mrst_wr");
    for (int k = 0; k < 4; k++) begin
      step_both(0, 0, 1, 0, 0, 0, "mrst_rd");
      chk("mrst_data", 32'(a_r_data), 32'h30 + k);
    end

    // ---- wrap-around: 40 units streamed through a 16-unit FIFO ----
    do_reset();
    wr_words = 0; rd_units = 0; cyc = 0; exp_byte = 8'h20;
    while (rd_units < 40 && cyc < 400) begin
      we = (wr_words < 10) && ($urandom_range(0, 3) != 0);
      re = ($urandom_range(0, 2) != 0);
      wd = 32'h23222120 + wr_words * 32'h04040404;
      wacc = we && (qa.size() <= 12);
      racc = re && (qa.size() >= 1);
      step_both(we, wd, re, 0, 0, 0, "wrap");
      if (wacc) wr_words++;
      if (racc) begin
        chk("wrap_data", 32'(a_r_data), 32'(exp_byte));
        exp_byte++;
        rd_units++;
      end
      cyc++;
    end
    chk("wrap_done", rd_units, 40);

    // ---- random traffic on both instances ----
    do_reset();
    for (int c = 0; c < 600; c++) begin
      step_both($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) != 0,
                $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 1) == 1, "rand");
    end

    idle_inputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iob_fifo_sync_asym.md
IOB_FIFO_SYNC_ASYM -- requirements
Module: iob_fifo_sync_asym

Interface
REQ-001 SHALL have parameter W_DATA_W, default 32, meaning write-port word width in bits.
REQ-002 SHALL have parameter R_DATA_W, default 8, meaning read-port word width in bits.
REQ-003 SHALL have parameter ADDR_W, default 4, meaning log2 of capacity counted in narrow words (MIN_W = min(W_DATA_W, R_DATA_W)).
REQ-004 SHALL accept only W_DATA_W/R_DATA_W ratios of 1, 2, 4 or 8 in either direction; W_UNITS = W_DATA_W/MIN_W, R_UNITS = R_DATA_W/MIN_W.
REQ-005 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port: w_en  input  1  write request.
REQ-008 SHALL have port: w_data  input  W_DATA_W  write word.
REQ-009 SHALL have port: w_full  output  1  high when a write cannot be accepted.
REQ-010 SHALL have port: r_en  input  1  read request.
REQ-011 SHALL have port: r_data  output  R_DATA_W  read word.
REQ-012 SHALL have port: r_valid  output  1  one-cycle pulse, r_data holds a newly read word.
REQ-013 SHALL have port: r_empty  output  1  high when a read cannot be accepted.
REQ-014 SHALL have port: level  output  ADDR_W+1  occupancy in narrow words.

Function
REQ-015 SHALL store data in an internal 2-port memory of 2^ADDR_W narrow units; write and read pointers count narrow units, modulo 2^ADDR_W.
REQ-016 SHALL pack little-endian: narrow unit k of a wide word occupies bits [k*MIN_W +: MIN_W]; lower unit = earlier in FIFO order.
REQ-017 SHALL drive w_full = (level > 2^ADDR_W - W_UNITS) and r_empty = (level < R_UNITS), combinationally from level.
REQ-018 SHALL accept a write when w_en=1 and w_full=0: store W_UNITS units at write pointer, advance pointer by W_UNITS.
REQ-019 SHALL accept a read when r_en=1 and r_empty=0: advance read pointer by R_UNITS; next cycle r_data = the R_UNITS oldest units, r_valid=1 (latency 1).
REQ-020 SHALL ignore w_en when w_full=1 and r_en when r_empty=1: no pointer/level change, r_data held, r_valid=0.
REQ-021 SHALL hold r_data between accepted reads; r_valid=0 in cycles following no accepted read.
REQ-022 SHALL update level each cycle by +W_UNITS per accepted write and -R_UNITS per accepted read; both in one cycle apply both; full/empty evaluated on pre-update level.
REQ-023 SHALL wrap pointers from 2^ADDR_W-1 to 0 without data loss; a wide access never straddles the wrap because pointers stay multiples of the respective unit counts.
REQ-024 SHALL make written data readable in the cycle after the write is accepted (no read-during-write bypass in the same cycle).
REQ-025 SHALL never let level exceed 2^ADDR_W or go below 0.

Reset
REQ-026 SHALL, when rst=1 at a clock edge, set pointers=0, level=0, r_data=0, r_valid=0; hence r_empty=1, w_full=0.
REQ-027 SHALL give rst priority over simultaneous w_en/r_en; mid-operation reset discards all contents, memory array need not be cleared.

Verification
REQ-028 SHALL cover (W=32,R=8,ADDR_W=4): write 0x23222120 -> level=4; 4 reads return 0x20,0x21,0x22,0x23, one r_valid pulse each, then r_empty=1.
REQ-029 SHALL cover full: 4 writes (0x23222120..0x2F2E2D2C) -> level=16, w_full=1; 5th write 0xDEADBEEF ignored; 16 reads return 0x20..0x2F in order.
REQ-030 SHALL cover (W=8,R=32,ADDR_W=4): write 0x20..0x22 -> r_empty=1, read ignored, r_valid=0; write 0x23..0x27 -> reads return 0x23222120 then 0x27262524.
REQ-031 SHALL cover simultaneous: level=8 (W=32,R=8), w_en and r_en same cycle -> level=11 next cycle, both operations complete.
REQ-032 SHALL cover wrap-around: 40 narrow units streamed through with level <= 16 -> sequence 0x20..0x47 read back intact.
REQ-033 SHALL cover reset mid-operation: rst at level=12 -> next cycle level=0, r_empty=1, w_full=0, r_data=0; subsequent write/read of 0x33323130 correct.
